// File: rtl/mips_pkg.sv
// Shared constants and FSM state type for the interrupt/cause logic.
package mips_pkg;

  localparam int IRQ_LINES  = 8;
  localparam int IRQ_CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } irq_state_t;

endpackage

// File: rtl/priority_enc.sv
// Combinational priority encoder: binary index of the highest set bit of cand.
module priority_enc #(
  parameter int bus_size_in  = 8,
  parameter int bus_size_out = 3
) (
  input  logic [bus_size_in-1:0]  cand,
  output logic [bus_size_out-1:0] index,
  output logic                    any_valid
);

  if (bus_size_in < 2 || bus_size_out != $clog2(bus_size_in)) begin : g_bad_width
    $error("priority_enc: bus_size_out must equal clog2(bus_size_in)");
  end

  // Ascending scan, so the highest set bit is the last one written.
  always_comb begin
    index     = '0;
    any_valid = 1'b0;
    for (int i = 0; i < bus_size_in; i++) begin
      if (cand[i]) begin
        index     = bus_size_out'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// Latches request edges as pending and grants the highest unmasked one under valid/ack.
module irq_priority_encoder
  import mips_pkg::*;
#(
  parameter int bus_size_in  = IRQ_LINES,
  parameter int bus_size_out = IRQ_CODE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [bus_size_in-1:0]  req,
  input  logic [bus_size_in-1:0]  mask,
  input  logic                    enabled,
  input  logic                    ack,
  input  logic                    clr_overrun,
  output logic [bus_size_out-1:0] out,
  output logic                    valid,
  output logic [bus_size_in-1:0]  pending,
  output logic [bus_size_in-1:0]  overrun
);

  if (bus_size_in < 2 || bus_size_out != $clog2(bus_size_in)) begin : g_bad_width
    $error("irq_priority_encoder: bus_size_out must equal clog2(bus_size_in)");
  end

  irq_state_t              state, next_state;
  logic [bus_size_in-1:0]  req_q;
  logic [bus_size_in-1:0]  req_edge;
  logic [bus_size_in-1:0]  ack_clr;
  logic [bus_size_in-1:0]  cand;
  logic [bus_size_out-1:0] sel_index;
  logic                    sel_any;
  logic                    grant;

  assign req_edge = req & ~req_q;
  assign cand     = pending & mask;

  priority_enc #(
    .bus_size_in (bus_size_in),
    .bus_size_out(bus_size_out)
  ) u_priority_enc (
    .cand     (cand),
    .index    (sel_index),
    .any_valid(sel_any)
  );

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    ack_clr    = '0;
    case (state)
      IDLE: begin
        if (enabled && sel_any) begin
          grant      = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (ack) begin
          ack_clr[out] = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An edge landing on the line being acked replaces the consumed event, so it is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      req_q   <= req;
      pending <= req_edge | (pending & ~ack_clr);
      overrun <= (clr_overrun ? '0 : overrun) | (req_edge & pending & ~ack_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      if (grant) begin
        out <= sel_index;
      end
      valid <= (next_state == BUSY);
    end
  end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Vector table and scoreboard queue checking irq_priority_encoder cycle by cycle.
module tb_irq_priority_encoder;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       enabled;
    logic       ack;
    logic       clr;
    logic [2:0] out;
    logic       valid;
    logic [7:0] pending;
    logic [7:0] overrun;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       enabled;
  logic       ack;
  logic       clr_overrun;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic [7:0] overrun;

  int   assert_count = 0;
  int   fail_count   = 0;
  vec_t vecs[$];
  vec_t expq[$];

  always #5 clk = ~clk;

  irq_priority_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask       (mask),
    .enabled    (enabled),
    .ack        (ack),
    .clr_overrun(clr_overrun),
    .out        (code),
    .valid      (valid),
    .pending    (pending),
    .overrun    (overrun)
  );

  function automatic vec_t mk(logic [7:0] r, logic [7:0] m, logic e, logic a, logic c,
                              logic [2:0] o, logic v, logic [7:0] p, logic [7:0] ov);
    vec_t t;
    t.req = r; t.mask = m; t.enabled = e; t.ack = a; t.clr = c;
    t.out = o; t.valid = v; t.pending = p; t.overrun = ov;
    return t;
  endfunction

  task automatic check(string name, int act, int exp);
    assert_count++;
    if (act != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs from the negedge and queue the post-edge expectation.
  task automatic applyStimulus(vec_t v);
    req         = v.req;
    mask        = v.mask;
    enabled     = v.enabled;
    ack         = v.ack;
    clr_overrun = v.clr;
    expq.push_back(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(string tag);
    vec_t e;
    if (expq.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = expq.pop_front();
    check({tag, "_out"}, int'(code), int'(e.out));
    check({tag, "_valid"}, int'(valid), int'(e.valid));
    check({tag, "_pending"}, int'(pending), int'(e.pending));
    check({tag, "_overrun"}, int'(overrun), int'(e.overrun));
  endtask

  task automatic runVec(vec_t v, string tag);
    applyStimulus(v);
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mask = 8'hFF; enabled = 1'b1; ack = 1'b0; clr_overrun = 1'b0;

    // Reset idle, single pulse, three-way ordering, masking, set-wins and overrun.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 0, 3'd0, 0, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd2, 1, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 3'd2, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd2, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 0, 0, 3'd2, 0, 8'hA1, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 0, 0, 3'd7, 1, 8'hA1, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 1, 0, 3'd7, 0, 8'h21, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 0, 0, 3'd5, 1, 8'h21, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 1, 0, 3'd5, 0, 8'h01, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 0, 0, 3'd0, 1, 8'h01, 8'h00));
    vecs.push_back(mk(8'hA1, 8'hFF, 1, 1, 0, 3'd0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h88, 8'h7F, 1, 0, 0, 3'd0, 0, 8'h88, 8'h00));
    vecs.push_back(mk(8'h88, 8'h7F, 1, 0, 0, 3'd3, 1, 8'h88, 8'h00));
    vecs.push_back(mk(8'h88, 8'hFF, 1, 0, 0, 3'd3, 1, 8'h88, 8'h00));
    vecs.push_back(mk(8'h88, 8'hFF, 1, 1, 0, 3'd3, 0, 8'h80, 8'h00));
    vecs.push_back(mk(8'h88, 8'hFF, 1, 0, 0, 3'd7, 1, 8'h80, 8'h00));
    vecs.push_back(mk(8'h88, 8'hFF, 1, 1, 0, 3'd7, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd7, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 0, 3'd7, 0, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd2, 1, 8'h04, 8'h00));
    vecs.push_back(mk(8'h04, 8'hFF, 1, 1, 0, 3'd2, 0, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd2, 1, 8'h04, 8'h00));
    vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 0, 3'd2, 1, 8'h04, 8'h04));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 3'd2, 1, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 3'd2, 0, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 0, 3'd2, 0, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 3'd2, 1, 8'h04, 8'h00));
    vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 1, 3'd2, 1, 8'h04, 8'h04));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 3'd2, 1, 8'h04, 8'h00));
    vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 3'd2, 0, 8'h00, 8'h00));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_valid", int'(valid), 0);
    check("reset_pending", int'(pending), 0);

    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    // Disabled grants still latch pending, then a line held through reset release.
    runVec(mk(8'h10, 8'hFF, 0, 0, 0, 3'd2, 0, 8'h10, 8'h00), "dis0");
    runVec(mk(8'h10, 8'hFF, 0, 0, 0, 3'd2, 0, 8'h10, 8'h00), "dis1");
    runVec(mk(8'h10, 8'hFF, 1, 0, 0, 3'd4, 1, 8'h10, 8'h00), "en");
    runVec(mk(8'h10, 8'h00, 0, 0, 0, 3'd4, 1, 8'h10, 8'h00), "busy_hold");

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_out", int'(code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runVec(mk(8'h10, 8'hFF, 1, 0, 0, 3'd0, 0, 8'h10, 8'h00), "held_edge");
    runVec(mk(8'h10, 8'hFF, 1, 0, 0, 3'd4, 1, 8'h10, 8'h00), "held_grant");
    runVec(mk(8'h10, 8'hFF, 1, 1, 0, 3'd4, 0, 8'h00, 8'h00), "held_ack");

    check("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
- Sequential priority encoder, the inverse of the one-hot `decoder`. It turns a vector of interrupt/event request lines into a binary index.
- Rising edges on request lines are latched as pending.
- The highest-index pending, unmasked line is presented as a binary code under a valid/ack handshake.
- Sits between peripheral request lines and the CPU cause/exception logic.

Parameters:
- bus_size_in, 8, number of request lines (≥2).
- bus_size_out, 3, code width; must equal clog2(bus_size_in). Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  bus_size_in  request lines; already synchronous to clk
- mask  input  bus_size_in  1 = line eligible for grant
- enabled  input  1  1 = new grants allowed
- ack  input  1  consumer accepts current code
- clr_overrun  input  1  clears overrun sticky bits
- out  output  bus_size_out  encoded index of the granted line
- valid  output  1  out holds a granted code
- pending  output  bus_size_in  latched pending vector
- overrun  output  bus_size_in  sticky: an edge arrived on an already-pending line

Behaviour:
- Reset, asynchronous on rst_n low:
  - out=0, valid=0, pending=0, overrun=0.
  - Internal req_q=0, state=IDLE.
- Edge detect, every cycle:
  - edge = req & ~req_q; req_q <= req.
  - A level held high produces exactly one edge.
  - A line held high through reset release produces an edge on the first cycle after reset.
- Pending update, per bit i, in priority order:
  1. edge[i] → pending[i]=1.
  2. else clear-on-ack of index i → pending[i]=0.
  3. else hold.
  - Set wins over ack-clear in the same cycle, so the event is re-pended.
- Overrun: edge[i] while pending[i]=1 → overrun[i]=1 (sticky). clr_overrun clears all bits; a simultaneous new overrun wins.
- Priority: cand = pending & mask. The selected index is the highest i with cand[i]=1.
- FSM states IDLE and BUSY:
  - IDLE: if enabled && |cand, then out <= selected index, valid <= 1, go to BUSY. Otherwise out holds its last value and valid=0.
  - BUSY: out and valid are held stable regardless of req, mask and enabled changes. A grant is never withdrawn.
  - BUSY with ack=1: pending[out] is cleared (subject to set-wins), valid <= 0, go to IDLE.
  - ack in IDLE is ignored.
- Latency:
  - req rising, sampled at edge k, sets pending at edge k.
  - The grant registers at edge k+1, so valid is visible after k+1 (2 cycles from request).
- Throughput: after ack, valid is low for at least one cycle, so back-to-back grants are 2 cycles apart.
- The pending computed at the grant edge uses the pre-update pending value. An edge in the same cycle is seen next cycle.
- enabled=0: no new grants; edges are still latched as pending.
- mask only gates selection; masked lines still accumulate pending and overrun.
- Reset mid-BUSY: immediate return to the reset values and the ungranted state. No ack is required.

Decomposition:
- Shared package `mips_pkg` holds:
  - the IRQ_LINES=8 and IRQ_CODE_W=3 constants;
  - the FSM state typedef {IDLE, BUSY}.
- One combinational sub-module, `priority_enc`, takes cand and produces index plus any_valid. It is parameterized by bus_size_in/bus_size_out and reused by the cause logic.
- Edge detect, pending/overrun registers and the FSM stay in the top module.

Test Plan:
1. Reset release with req=0, mask=8'hFF, enabled=1 → out=0, valid=0, pending=0 for 5 cycles.
2. Pulse req=8'b0000_0100 for one cycle → pending=8'h04 after edge k, valid=1 and out=3'd2 after k+1; ack for one cycle → valid=0, pending=0.
3. req=8'b1010_0001 rising together, mask=8'hFF → grants in order out=7, 5, 0, each on ack. valid drops for one cycle between grants.
4. req=8'h80 with mask=8'h7F, plus req bit 3 → out=3; then mask=8'hFF → after ack, out=7.
5. Grant out=2 outstanding; a new pulse on req[2] lands in the ack cycle → pending[2] stays 1, overrun[2]=0, and out=2 is re-granted 2 cycles later. A second pulse while pending → overrun[2]=1; clr_overrun → 0.
6. enabled=0 with req=8'h10 → pending=8'h10, valid stays 0; set enabled=1 → out=4, valid=1 next cycle. Assert rst_n=0 mid-BUSY → valid=0 and pending=0 asynchronously.
